// File: rtl/booth_mul_ctrl_if.sv
// Request/result handshake bundle between the EXU and the booth_mul_ctrl multiplier.
// The EXU drives the master side; the multiplier controller is the slave.
interface booth_mul_ctrl_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            in_x_signed;
  logic            in_y_signed;
  logic            in_high;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_src1, in_src2, in_x_signed, in_y_signed, in_high, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_x_signed, in_y_signed, in_high, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier controller (one group per cycle) for RV64 MUL/MULH/MULHSU/MULHU.
// Optional macro BOOTH_MUL_EARLY_EXIT_EN ends the BUSY phase once the remaining multiplier bits are uniform.
module booth_mul_ctrl #(
  parameter int XLEN = 64,
  parameter int NGRP = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  booth_mul_ctrl_if.slave  bus,
  output logic             busy
);
  localparam int XW = XLEN + 1;      // sign/zero-extended multiplicand
  localparam int YW = XLEN + 3;      // {e, e, src2, y[-1]}
  localparam int AW = 2 * XLEN + 1;  // accumulator width
  localparam int GW = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [AW-1:0]   acc_r;
  logic [GW-1:0]   grp_r;
  logic            high_r;
  logic            in_ready_r, out_valid_r, busy_r;
  logic [XLEN-1:0] out_result_r;

  logic [AW-1:0]   pp_s;
  logic [AW-1:0]   acc_next_s;
  logic            last_grp_s;
  logic            uniform_s;
  logic            grp_done_s;
  logic            accept_s;

  // booth_pmgen: radix-4 digit selection of +-0/X/2X, sign-extended to the accumulator width
  function automatic logic [AW-1:0] booth_pmgen(input logic [XW-1:0] x_in, input logic [2:0] y_in);
    logic [AW-1:0] xe;
    logic [AW-1:0] p;
    xe = {{(AW-XW){x_in[XW-1]}}, x_in};
    case (y_in)
      3'b001, 3'b010: p = xe;
      3'b011:         p = xe << 1;
      3'b100:         p = {AW{1'b0}} - (xe << 1);
      3'b101, 3'b110: p = {AW{1'b0}} - xe;
      default:        p = {AW{1'b0}};
    endcase
    return p;
  endfunction

  assign pp_s       = booth_pmgen(x_r, y_r[2:0]);
  assign acc_next_s = acc_r + (pp_s << {grp_r, 1'b0});
  assign last_grp_s = (grp_r == GW'(NGRP - 1));
  assign accept_s   = (state_r == ST_IDLE) && bus.in_valid && !flush;

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // y_r[YW-1:2] are the multiplier bits above the group just retired; uniform means all later digits are zero
  assign uniform_s  = (&y_r[YW-1:2]) | ~(|y_r[YW-1:2]);
`else
  assign uniform_s  = 1'b0;
`endif
  assign grp_done_s = last_grp_s | uniform_s;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = bus.in_valid ? ST_BUSY : ST_IDLE;
        ST_BUSY: state_next_s = grp_done_s ? ST_DONE : ST_BUSY;
        ST_DONE: state_next_s = bus.out_ready ? ST_IDLE : ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Operand capture, group accumulation and registered handshake outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      acc_r        <= {AW{1'b0}};
      grp_r        <= {GW{1'b0}};
      high_r       <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
      if (accept_s) begin
        x_r    <= {bus.in_x_signed & bus.in_src1[XLEN-1], bus.in_src1};
        y_r    <= {{2{bus.in_y_signed & bus.in_src2[XLEN-1]}}, bus.in_src2, 1'b0};
        acc_r  <= {AW{1'b0}};
        grp_r  <= {GW{1'b0}};
        high_r <= bus.in_high;
      end else if ((state_r == ST_BUSY) && !flush) begin
        acc_r <= acc_next_s;
        grp_r <= grp_r + GW'(1);
        y_r   <= {{2{y_r[YW-1]}}, y_r[YW-1:2]};
        if (grp_done_s) begin
          out_result_r <= high_r ? acc_next_s[2*XLEN-1:XLEN] : acc_next_s[XLEN-1:0];
        end else begin
          out_result_r <= out_result_r;
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign busy           = busy_r;
endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
Iterative radix-4 Booth multiplier controller for the RV64 M-extension MUL/MULH/MULHSU/MULHU path. It latches two 64-bit operands and extends them to 65 bits according to per-operand signedness. It then retires one Booth group per cycle, feeding a booth_pmgen partial-product generator and a 129-bit accumulator. The selected 64-bit half of the product is returned over a valid/ready handshake to the EXU.

Parameters:
XLEN, 64, operand/result width; the module is only required to work at 64.
NGRP, 33, Booth groups per operation; equals (XLEN+2)/2 for the 66-bit extended multiplier.

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
flush  input  1  abort current operation; synchronous
in_valid  input  1  request valid
in_ready  output  1  controller can accept
in_src1  input  64  multiplicand X
in_src2  input  64  multiplier Y
in_x_signed  input  1  1: sign-extend X; 0: zero-extend
in_y_signed  input  1  1: sign-extend Y; 0: zero-extend
in_high  input  1  1: return product[127:64]; 0: product[63:0]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  64  selected product half
busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, accumulator=0, group counter=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load registers and go to BUSY.
  - BUSY: one group per cycle. After the group with index NGRP-1, go to DONE.
  - DONE: out_valid=1 and out_result is held stable. On out_valid&out_ready, go to IDLE.
- Load on accept:
  - X65 = {ext(src1[63]), src1}, where ext = src1[63] if x_signed, else 0.
  - Y66 = {e,e,src2}, where e = src2[63] if y_signed, else 0.
  - Y has an implicit y[-1]=0.
  - acc=0, grp=0, in_high latched.
- Group i (0..32): y_in = {Y66[2i+1], Y66[2i], Y66[2i-1]}, with x_in = X65 going to booth_pmgen. Its 129-bit p is shifted left by 2i (truncated to 129 bits) and added to acc, mod 2^129.
- Result: product = acc[127:0]. out_result = in_high ? acc[127:64] : acc[63:0].
- Latency: accept edge = cycle 0. BUSY covers cycles 1..33 and out_valid first rises in cycle 34. out_valid falls the cycle after the output handshake.
- in_ready is 1 only in IDLE. A new request is never accepted in the same cycle as result handoff, so minimum issue interval is 35 cycles.
- Backpressure: DONE is held indefinitely while out_ready=0, with out_result stable.
- flush:
  - Priority: reset > flush > handshakes.
  - flush=1 at an edge forces IDLE and out_valid=0 and drops any pending result.
  - An in_valid in the same cycle as flush is not accepted.
  - flush in IDLE has no effect.
- Reset mid-operation: identical to power-on reset, and the partial accumulator is discarded.
- Inputs are sampled only on accept. Changes to src/flags while BUSY have no effect.

Optional Feature:
Macro BOOTH_MUL_EARLY_EXIT_EN.
- Defined: after group i is accumulated, if Y66[65:2i+1] are all equal, all remaining groups are zero and the controller goes directly to DONE. BUSY lasts 1..33 cycles, with a minimum of 1 (e.g. Y=0 or Y=-1 signed). Results are bit-identical to the non-early-exit build.
- Undefined: always exactly 33 BUSY cycles, with no uniformity detection logic.

Test Plan:
- MUL: X=3, Y=5, both signed, high=0 → out_result=0x000000000000000F. out_valid at cycle 34, or cycle 3 with BOOTH_MUL_EARLY_EXIT_EN.
- MULHU: X=Y=0xFFFFFFFFFFFFFFFF, unsigned, high=1 → 0xFFFFFFFFFFFFFFFE. The same operands with MUL (low half) → 0x0000000000000001.
- MULH: X=Y=0x8000000000000000, signed, high=1 → 0x4000000000000000. Also MULH X=Y=-1 → 0x0000000000000000.
- MULHSU: X=0xFFFFFFFFFFFFFFFF (signed), Y=0xFFFFFFFFFFFFFFFF (unsigned), high=1 → 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_result is stable, in_ready=0. Then pulse out_ready → IDLE next cycle and in_ready=1.
- Flush/reset: assert flush at BUSY cycle 10 with in_valid=1 → IDLE next cycle, no out_valid, request not accepted. Repeat with reset_n=0 at BUSY cycle 20 → all outputs at reset values next cycle.
